// File: rtl/toggle_event_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : toggle_event_decoder_if
// Purpose  : Toggle-event bus carrying the remote toggle level, consumer
//            controls and the decoded event outputs.
// Revision : 1.0  initial release
// ============================================================================
interface toggle_event_decoder_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 toggle_in;
  logic                 clear;
  logic                 evt_ack;
  logic                 evt_pulse;
  logic                 evt_valid;
  logic                 evt_level;
  logic [CNT_WIDTH-1:0] evt_count;
  logic                 overrun;

  modport master (
    output toggle_in,
    output clear,
    output evt_ack,
    input  evt_pulse,
    input  evt_valid,
    input  evt_level,
    input  evt_count,
    input  overrun
  );

  modport slave (
    input  toggle_in,
    input  clear,
    input  evt_ack,
    output evt_pulse,
    output evt_valid,
    output evt_level,
    output evt_count,
    output overrun
  );
endinterface
`default_nettype wire

// File: rtl/toggle_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : toggle_event_decoder
// Purpose  : Synchronises a remote toggle level, turns each level change into
//            a pulse, counts events and presents them through valid/ack.
// Revision : 1.0  initial release
// ============================================================================
module toggle_event_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  toggle_event_decoder_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 r_state;
  state_t                 w_state_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_ref;
  logic                   r_pulse;
  logic                   r_level;
  logic                   r_overrun;
  logic [CNT_WIDTH-1:0]   r_count;
  logic                   w_sync_out;
  logic                   w_event;
  logic                   w_overrun_set;

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_event    = w_sync_out ^ r_ref;

  // Shift register synchroniser; the oldest stage is the only one observed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.toggle_in};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_overrun_set = 1'b0;
    if (bus.clear) begin
      w_state_next = w_event ? PENDING : IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_event) begin
            w_state_next = PENDING;
          end
        end
        PENDING: begin
          if (w_event) begin
            w_state_next  = PENDING;
            w_overrun_set = ~bus.evt_ack;
          end else if (bus.evt_ack) begin
            w_state_next = IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // clear never touches r_ref, so it cannot fabricate or swallow an event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ref     <= 1'b0;
      r_pulse   <= 1'b0;
      r_level   <= 1'b0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_pulse <= w_event;
      if (w_event) begin
        r_ref   <= w_sync_out;
        r_level <= w_sync_out;
      end
      if (bus.clear) begin
        r_count <= w_event ? c_CNT_ONE : '0;
      end else if (w_event) begin
        r_count <= r_count + c_CNT_ONE;
      end
      if (bus.clear) begin
        r_overrun <= 1'b0;
      end else if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign bus.evt_pulse = r_pulse;
  assign bus.evt_valid = (r_state == PENDING);
  assign bus.evt_level = r_level;
  assign bus.evt_count = r_count;
  assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire
